pingpong_line_buffer: RTL and testbench
=======================================

PINGPONG_LINE_BUFFER -- requirements
Module: pingpong_line_buffer

Interface
REQ-001 Parameter DATA_W, 14, width of one ADC pixel word.
REQ-002 Parameter CHANNELS, 2, pixels delivered per write beat; legal values 1, 2, 4.
REQ-003 Parameter PIX_IN_ROW, 640, pixels per line and depth of each bank; SHALL be a multiple of CHANNELS.
REQ-004 Parameter CNT_W, 10, counter width; SHALL satisfy 2^CNT_W > PIX_IN_ROW.
REQ-005 Port CLK  input  1  single clock; all state changes on rising edge.
REQ-006 Port RESET_N  input  1  asynchronous active-low reset.
REQ-007 Port LINE_START  input  1  one-cycle pulse marking the start of an incoming line.
REQ-008 Port WR_EN  input  1  write beat qualifier.
REQ-009 Port DATA_IN  input  CHANNELS*DATA_W  pixels of one beat; channel 0 in the LSBs holds the lowest pixel index.
REQ-010 Port RD_READY  input  1  downstream accepts RD_DATA.
REQ-011 Port RD_DATA  output  DATA_W  pixel out, registered.
REQ-012 Port RD_VALID  output  1  RD_DATA valid.
REQ-013 Port RD_LAST  output  1  high with pixel PIX_IN_ROW-1 of a line.
REQ-014 Port LINE_DROP  output  1  one-cycle pulse: incoming line discarded.
REQ-015 Port BANK_BUSY  output  2  bit i high while bank i is FULL or DRAINING.

Function
REQ-016 Two banks of PIX_IN_ROW x DATA_W (block RAM, synchronous read); each bank has state EMPTY, FILLING, FULL, DRAINING.
REQ-017 All availability decisions SHALL use bank state as held before the current edge.
REQ-018 LINE_START with an EMPTY bank (bank 0 preferred if both EMPTY): that bank goes FILLING, write count = 0.
REQ-019 LINE_START with no EMPTY bank and no bank FILLING: LINE_DROP pulses the next cycle; WR_EN beats ignored until the next LINE_START.
REQ-020 LINE_START while a bank is FILLING: same bank restarts at count 0; the partial line is discarded without LINE_DROP.
REQ-021 LINE_START and WR_EN in the same cycle: that beat is written at addresses 0..CHANNELS-1 of the new line.
REQ-022 WR_EN beat into a FILLING bank: channel k written at address count+k; count += CHANNELS.
REQ-023 Beat bringing count to PIX_IN_ROW: bank goes FULL at that edge; further WR_EN beats ignored until LINE_START.
REQ-024 WR_EN with no line open (before first LINE_START, after completion, after drop): ignored, no flag.
REQ-025 Read side IDLE and some bank FULL: it claims the bank filled earliest (fill-order bit) at the next edge; bank goes DRAINING, read count = 0.
REQ-026 RD_VALID SHALL rise at the edge after the claim with pixel 0; end-to-end latency from last-write edge to first RD_VALID = 2 cycles.
REQ-027 Transfer occurs on RD_VALID & RD_READY; the next pixel appears at the following edge; RD_DATA, RD_LAST held stable while RD_VALID=1 and RD_READY=0.
REQ-028 Pixels SHALL emerge in ascending index order, one per transfer, at full rate under continuous RD_READY.
REQ-029 Transfer with RD_LAST=1: bank goes EMPTY, read side IDLE, RD_VALID=0 at that edge; the next FULL bank is claimed one edge later (2-cycle bubble).
REQ-030 Write and read on different banks in the same cycle SHALL not interfere; a bank released to EMPTY at an edge is reusable by a LINE_START in the following cycle only.

Reset
REQ-031 RESET_N low: both banks EMPTY, write side closed, read side IDLE, fill-order bit 0, counters 0.
REQ-032 Outputs during and after reset: RD_DATA=0, RD_VALID=0, RD_LAST=0, LINE_DROP=0, BANK_BUSY=2'b00.
REQ-033 Reset mid-line or mid-drain discards all buffered lines; RAM contents are not cleared and never reappear at the output.

Verification (PIX_IN_ROW=8, CHANNELS=2, DATA_W=14)
REQ-034 LINE_START+4 beats of pixel pairs {1,0},{3,2},{5,4},{7,6}, RD_READY=1 -> RD_DATA 0..7 on 8 consecutive cycles from 2 cycles after the 4th beat; RD_LAST only with 7; BANK_BUSY=01 then 00.
REQ-035 Same line, RD_READY toggled 1,0,0,1,... -> no loss or duplication; RD_DATA stable during stalls.
REQ-036 Three lines back-to-back, RD_READY=0 -> lines 1,2 fill banks 0,1; third LINE_START gives a LINE_DROP pulse; then RD_READY=1 -> line 1 then line 2 output, 2-cycle bubble between.
REQ-037 LINE_START after 2 beats then full line of values 100..107 -> output 100..107 only; no LINE_DROP.
REQ-038 RESET_N low for 1 cycle during drain at pixel 3 -> RD_VALID=0, BANK_BUSY=00 immediately; no output until a new line completes.
REQ-039 WR_EN beats without LINE_START after reset -> no output, no LINE_DROP, BANK_BUSY=00.

Source files
------------

// File: rtl/pingpong_line_buffer.sv
// pingpong_line_buffer
//
// Double-buffered line store that sits between an ADC pixel stream and a
// downstream consumer. Incoming lines land in one of two banks, several
// pixels per beat. Completed lines are played back one pixel per handshake,
// oldest line first. While one bank drains, the other bank can fill.
//
// Ports:
//   CLK         single clock, all state changes on the rising edge
//   RESET_N     asynchronous active-low reset
//   LINE_START  one-cycle pulse at the start of an incoming line
//   WR_EN       write beat qualifier for DATA_IN
//   DATA_IN     CHANNELS pixels per beat, channel 0 (lowest index) in the LSBs
//   RD_READY    downstream accepts RD_DATA
//   RD_DATA     registered pixel output
//   RD_VALID    RD_DATA holds a valid pixel
//   RD_LAST     qualifies the final pixel of a line
//   LINE_DROP   one-cycle pulse when an incoming line had to be discarded
//   BANK_BUSY   bit i set while bank i holds a complete line (FULL or DRAINING)

module pingpong_line_buffer #(
  parameter int DATA_W     = 14,
  parameter int CHANNELS   = 2,
  parameter int PIX_IN_ROW = 640,
  parameter int CNT_W      = 10
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       LINE_START,
  input  logic                       WR_EN,
  input  logic [CHANNELS*DATA_W-1:0] DATA_IN,
  input  logic                       RD_READY,
  output logic [DATA_W-1:0]          RD_DATA,
  output logic                       RD_VALID,
  output logic                       RD_LAST,
  output logic                       LINE_DROP,
  output logic [1:0]                 BANK_BUSY
);

  // Each bank is stored as beat-wide words so one write beat is one RAM write.
  localparam int WORDS    = PIX_IN_ROW / CHANNELS;
  localparam int WA_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CH_SHIFT = $clog2(CHANNELS);

  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(PIX_IN_ROW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_IN_ROW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_STREAM
  } rd_state_t;

  bank_state_t bank_state     [2];
  bank_state_t bank_state_nxt [2];
  rd_state_t   rd_state;
  rd_state_t   rd_state_nxt;

  logic [CHANNELS*DATA_W-1:0] mem [2][WORDS];

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_base;
  logic [CNT_W-1:0] rd_cnt;
  logic [WA_W-1:0]  wr_addr;
  logic [WA_W-1:0]  rd_addr;
  logic [CH_W-1:0]  rd_chan;
  logic             rd_bank;
  logic             fill_first;

  logic any_filling;
  logic fill_idx;
  logic any_empty;
  logic empty_idx;
  logic full0;
  logic full1;
  logic any_full;
  logic claim_idx;
  logic start_open;
  logic start_drop;
  logic wr_bank;
  logic write_go;
  logic wr_done;
  logic claim;
  logic load;
  logic rd_release;

  // Write-side decisions, all taken from bank state as it stood before this
  // edge. A line that is still filling always wins a LINE_START so the
  // partial line is simply restarted in place; otherwise an empty bank is
  // opened, bank 0 first. With neither available the line is dropped. Since
  // a bank is FILLING exactly while a line is open, no separate "line open"
  // flag is needed.
  always_comb begin
    any_filling = (bank_state[0] == BANK_FILLING) || (bank_state[1] == BANK_FILLING);
    fill_idx    = (bank_state[1] == BANK_FILLING);
    any_empty   = (bank_state[0] == BANK_EMPTY) || (bank_state[1] == BANK_EMPTY);
    empty_idx   = (bank_state[0] != BANK_EMPTY);
    full0       = (bank_state[0] == BANK_FULL);
    full1       = (bank_state[1] == BANK_FULL);
    any_full    = full0 || full1;
    claim_idx   = (full0 && full1) ? fill_first : full1;
    start_open  = LINE_START && (any_filling || any_empty);
    start_drop  = LINE_START && !any_filling && !any_empty;
    wr_bank     = any_filling ? fill_idx : empty_idx;
    write_go    = WR_EN && (any_filling || start_open);
    wr_base     = LINE_START ? '0 : wr_cnt;
    wr_done     = write_go && ((wr_base + CNT_STEP) == CNT_END);
  end

  assign wr_addr = WA_W'(wr_base >> CH_SHIFT);
  assign rd_addr = WA_W'(rd_cnt >> CH_SHIFT);
  assign rd_chan = CH_W'(rd_cnt & (CNT_STEP - CNT_ONE));

  // Read-side sequencing. A claim takes one edge, the first RAM fetch a
  // second, so the first pixel appears two edges after the bank went FULL.
  // In STREAM the next pixel is fetched only on a completed transfer, which
  // keeps RD_DATA and RD_LAST frozen during back-pressure.
  always_comb begin
    rd_state_nxt = rd_state;
    claim        = 1'b0;
    load         = 1'b0;
    rd_release   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (any_full) begin
          claim        = 1'b1;
          rd_state_nxt = RD_LOAD;
        end
      end
      RD_LOAD: begin
        load         = 1'b1;
        rd_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        if (RD_READY) begin
          if (RD_LAST) begin
            rd_release   = 1'b1;
            rd_state_nxt = RD_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Per-bank lifecycle. The write side only touches EMPTY/FILLING banks and
  // the read side only FULL/DRAINING ones, so the updates never collide on
  // the same bank within one edge.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_nxt[b] = bank_state[b];
      if (start_open && (wr_bank == 1'(b))) begin
        bank_state_nxt[b] = BANK_FILLING;
      end
      if (wr_done && (wr_bank == 1'(b))) begin
        bank_state_nxt[b] = BANK_FULL;
      end
      if (claim && (claim_idx == 1'(b))) begin
        bank_state_nxt[b] = BANK_DRAINING;
      end
      if (rd_release && (rd_bank == 1'(b))) begin
        bank_state_nxt[b] = BANK_EMPTY;
      end
    end
  end

  // Control and output registers. fill_first names the older of two FULL
  // banks: a bank completing while the other already waits is the younger
  // one. RD_DATA doubles as the RAM read register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      rd_state      <= RD_IDLE;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      rd_bank       <= 1'b0;
      fill_first    <= 1'b0;
      RD_DATA       <= '0;
      RD_LAST       <= 1'b0;
      LINE_DROP     <= 1'b0;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
      rd_state      <= rd_state_nxt;
      LINE_DROP     <= start_drop;
      if (start_open || write_go) begin
        wr_cnt <= write_go ? (wr_base + CNT_STEP) : '0;
      end
      if (wr_done) begin
        fill_first <= (bank_state[~wr_bank] == BANK_FULL) ? ~wr_bank : wr_bank;
      end
      if (claim) begin
        rd_bank <= claim_idx;
        rd_cnt  <= '0;
      end
      if (load) begin
        RD_DATA <= mem[rd_bank][rd_addr][rd_chan*DATA_W +: DATA_W];
        RD_LAST <= (rd_cnt == CNT_LAST);
        rd_cnt  <= rd_cnt + CNT_ONE;
      end
      if (rd_release) begin
        RD_LAST <= 1'b0;
      end
    end
  end

  // Pixel storage. Kept out of reset so it maps onto block RAM; stale
  // contents are unreachable because only FULL banks are ever read.
  always_ff @(posedge CLK) begin
    if (write_go) begin
      mem[wr_bank][wr_addr] <= DATA_IN;
    end
  end

  assign RD_VALID     = (rd_state == RD_STREAM);
  assign BANK_BUSY[0] = (bank_state[0] == BANK_FULL) || (bank_state[0] == BANK_DRAINING);
  assign BANK_BUSY[1] = (bank_state[1] == BANK_FULL) || (bank_state[1] == BANK_DRAINING);

endmodule

// File: tb/tb_pingpong_line_buffer.sv
// tb_pingpong_line_buffer
//
// Directed bench for pingpong_line_buffer with 8-pixel lines, two channels
// per beat and 14-bit pixels. Inputs change on the falling edge and outputs
// are sampled on the falling edge, half a cycle clear of the active edge.

module tb_pingpong_line_buffer;

  localparam int DATA_W     = 14;
  localparam int CHANNELS   = 2;
  localparam int PIX_IN_ROW = 8;
  localparam int CNT_W      = 4;

  logic                       CLK;
  logic                       RESET_N;
  logic                       LINE_START;
  logic                       WR_EN;
  logic [CHANNELS*DATA_W-1:0] DATA_IN;
  logic                       RD_READY;
  logic [DATA_W-1:0]          RD_DATA;
  logic                       RD_VALID;
  logic                       RD_LAST;
  logic                       LINE_DROP;
  logic [1:0]                 BANK_BUSY;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    bit ls;
    bit wr;
    int hi;
    int lo;
    bit rdy;
    bit e_valid;
    int e_data;
    bit e_last;
    bit e_drop;
    int e_busy;
  } vec_t;

  vec_t vecs[14];

  pingpong_line_buffer #(
    .DATA_W     (DATA_W),
    .CHANNELS   (CHANNELS),
    .PIX_IN_ROW (PIX_IN_ROW),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .LINE_START (LINE_START),
    .WR_EN      (WR_EN),
    .DATA_IN    (DATA_IN),
    .RD_READY   (RD_READY),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID),
    .RD_LAST    (RD_LAST),
    .LINE_DROP  (LINE_DROP),
    .BANK_BUSY  (BANK_BUSY)
  );

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case some wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(bit ls, bit wr, int hi, int lo, bit rdy,
                                 bit ev, int ed, bit el, bit edrop, int ebusy);
    vec_t v;
    v.ls = ls; v.wr = wr; v.hi = hi; v.lo = lo; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_drop = edrop; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and advance to the next falling edge.
  task automatic applyStimulus(input bit ls, input bit wr, input int hi, input int lo, input bit rdy);
    LINE_START = ls;
    WR_EN      = wr;
    DATA_IN    = {14'(hi), 14'(lo)};
    RD_READY   = rdy;
    @(negedge CLK);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, RD_READY);
  endtask

  // Four beats carrying pixels base..base+7, LINE_START on the first beat.
  task automatic sendLine(input int base, input bit exp_drop, input bit rdy);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(b == 0, 1'b1, base + 2*b + 1, base + 2*b, rdy);
      checkOutput("line_drop", int'(LINE_DROP), (b == 0) ? int'(exp_drop) : 0);
    end
  endtask

  // Consume one line expecting pixels base..base+7. mode 0: RD_READY held
  // high; mode 1: RD_READY follows 1,0,0 repeating. exp_wait >= 0 checks
  // the number of sampled cycles without RD_VALID before the first pixel.
  task automatic readLine(input int base, input int mode, input int exp_wait);
    int idx = 0;
    int waitc = 0;
    int k = 0;
    int held = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    LINE_START = 1'b0;
    WR_EN      = 1'b0;
    while (idx < 8 && k < 100) begin
      rdy = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (RD_VALID) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_wait >= 0) checkOutput("bubble_cycles", waitc, exp_wait);
        end
        if (stalled) checkOutput("stall_hold", int'(RD_DATA), held);
        if (rdy) begin
          checkOutput("rd_data", int'(RD_DATA), base + idx);
          checkOutput("rd_last", int'(RD_LAST), (idx == 7) ? 1 : 0);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = int'(RD_DATA);
        end
      end else if (!seen) begin
        waitc++;
      end else begin
        checkOutput("rd_valid_gap", int'(RD_VALID), 1);
      end
      RD_READY = rdy;
      @(negedge CLK);
      k++;
    end
    checkOutput("line_complete", idx, 8);
    checkOutput("valid_after_last", int'(RD_VALID), 0);
  endtask

  task automatic checkQuiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      idleCycles(1);
      checkOutput({tag, "_valid"}, int'(RD_VALID), 0);
      checkOutput({tag, "_drop"}, int'(LINE_DROP), 0);
      checkOutput({tag, "_busy"}, int'(BANK_BUSY), 0);
    end
  endtask

  initial begin
    int  guard;
    bit  found;

    // Single-line playback at full rate: four beats, then pixels 0..7.
    vecs[0] = mkVec(1, 1, 1, 0, 1,  0, 0, 0, 0, 0);
    vecs[1] = mkVec(0, 1, 3, 2, 1,  0, 0, 0, 0, 0);
    vecs[2] = mkVec(0, 1, 5, 4, 1,  0, 0, 0, 0, 0);
    vecs[3] = mkVec(0, 1, 7, 6, 1,  0, 0, 0, 0, 1);
    vecs[4] = mkVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    for (int i = 5; i <= 12; i++) begin
      vecs[i] = mkVec(0, 0, 0, 0, 1,  1, i - 5, (i == 12), 0, 1);
    end
    vecs[13] = mkVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

    RESET_N    = 1'b0;
    LINE_START = 1'b0;
    WR_EN      = 1'b0;
    DATA_IN    = '0;
    RD_READY   = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("reset_rd_data", int'(RD_DATA), 0);
    checkOutput("reset_rd_valid", int'(RD_VALID), 0);
    checkOutput("reset_rd_last", int'(RD_LAST), 0);
    checkOutput("reset_line_drop", int'(LINE_DROP), 0);
    checkOutput("reset_bank_busy", int'(BANK_BUSY), 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("post_reset_valid", int'(RD_VALID), 0);
    checkOutput("post_reset_busy", int'(BANK_BUSY), 0);

    $display("[TB] write beats with no open line");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2*i + 1, 2*i, 1'b1);
    checkQuiet("no_line", 6);

    $display("[TB] table: single line, continuous ready");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].ls, vecs[i].wr, vecs[i].hi, vecs[i].lo, vecs[i].rdy);
      checkOutput($sformatf("v%0d_valid", i), int'(RD_VALID), int'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d_last", i), int'(RD_LAST), int'(vecs[i].e_last));
      checkOutput($sformatf("v%0d_drop", i), int'(LINE_DROP), int'(vecs[i].e_drop));
      checkOutput($sformatf("v%0d_busy", i), int'(BANK_BUSY), vecs[i].e_busy);
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("v%0d_data", i), int'(RD_DATA), vecs[i].e_data);
      end
    end

    $display("[TB] single line with stalls");
    sendLine(0, 1'b0, 1'b0);
    readLine(0, 1, -1);
    idleCycles(1);
    checkOutput("stall_busy_end", int'(BANK_BUSY), 0);

    $display("[TB] three lines back to back, third dropped");
    RD_READY = 1'b0;
    sendLine(10, 1'b0, 1'b0);
    sendLine(20, 1'b0, 1'b0);
    sendLine(30, 1'b1, 1'b0);
    checkOutput("both_busy", int'(BANK_BUSY), 3);
    readLine(10, 0, 0);
    readLine(20, 0, 2);
    checkQuiet("after_drop", 4);

    $display("[TB] restarted partial line");
    applyStimulus(1'b1, 1'b1, 901, 900, 1'b1);
    checkOutput("partial_drop0", int'(LINE_DROP), 0);
    applyStimulus(1'b0, 1'b1, 903, 902, 1'b1);
    checkOutput("partial_drop1", int'(LINE_DROP), 0);
    sendLine(100, 1'b0, 1'b1);
    readLine(100, 0, -1);
    checkQuiet("after_restart", 4);

    $display("[TB] reset during drain");
    sendLine(40, 1'b0, 1'b1);
    LINE_START = 1'b0;
    WR_EN      = 1'b0;
    RD_READY   = 1'b1;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 50) begin
      if (RD_VALID && (RD_DATA == 14'd43)) found = 1'b1;
      else begin
        @(negedge CLK);
        guard++;
      end
    end
    checkOutput("drain_reached_pixel3", int'(found), 1);
    RESET_N = 1'b0;
    #1;
    checkOutput("midreset_valid", int'(RD_VALID), 0);
    checkOutput("midreset_busy", int'(BANK_BUSY), 0);
    checkOutput("midreset_data", int'(RD_DATA), 0);
    checkOutput("midreset_last", int'(RD_LAST), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    checkQuiet("after_midreset", 8);
    sendLine(60, 1'b0, 1'b1);
    readLine(60, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
